commit_ctrl: RTL and testbench
==============================

// Module: commit_ctrl
// PURPOSE
//  Sequential commit controller at the ROB head. Each cycle it decides whether the head entry may retire and pops it.
//  It drives register-file writeback, store-release to the LSB and PC redirect/flush on taken control flow.
//  Stores are serialized: nothing further retires until the LSB acknowledges the store. Sits between ROB, regfile, LSB and IF.
// PARAMETERS
//  TAG_W        4   ROB tag width (ROB depth = 2**TAG_W)
//  FLUSH_CYCLES 2   cycles flush_out is held after a redirect (>=1)
// PORTS
//  clk_in              in   1            clock, all state on posedge
//  rst_in              in   1            async reset, active-high
//  rdy_in              in   1            global ready; low = freeze
//  head_valid_in       in   1            ROB non-empty
//  head_ready_in       in   1            head result available
//  head_tag_in         in   TAG_W        ROB tag of head
//  head_instr_id_in    in   InstrIdWidth head instruction id (config.vh encoding)
//  head_rd_in          in   5            destination register
//  head_value_in       in   32           result value
//  head_jump_en_in     in   1            control transfer taken / mispredicted
//  head_jump_a_in      in   AddrWidth    redirect target
//  lsb_store_done_in   in   1            LSB finished released store (1-cycle pulse)
//  rob_pop_out         out  1            pop ROB head (1-cycle pulse)
//  rf_wr_en_out        out  1            regfile write strobe
//  rf_rd_out           out  5            regfile write index
//  rf_value_out        out  32           regfile write data
//  rf_tag_out          out  TAG_W        tag to clear regfile rename if matching
//  lsb_store_commit_out out 1            release head store to memory (pulse)
//  pc_redirect_en_out  out  1            load PC (pulse)
//  pc_redirect_a_out   out  AddrWidth    new PC
//  flush_out           out  1            clear speculative state (ROB/RS/LSB/regfile tags)
//  commit_cnt_out      out  32           retired instruction count
// BEHAVIOUR
//  Classes (config.vh ids): WRITES_RD = id<=`LHU | `LUI<=id<=`JALR | id>=`ADDI;
//   CTRL = `JAL<=id<=`BGEU; STORE = `SB<=id<=`SW.
//  All outputs registered; reset (async): state=RUN, every output 0, commit_cnt_out=0, flush counter 0.
//  FSM states: RUN, STORE_WAIT, FLUSH.
//  RUN: retire iff rdy_in & head_valid_in & head_ready_in. On retire, next cycle:
//   rob_pop_out=1; commit_cnt_out+=1 (wraps at 2**32).
//   WRITES_RD & rd!=0 -> rf_wr_en_out=1, rf_rd_out/value/tag = head fields; rd==0 -> no write.
//   STORE -> lsb_store_commit_out=1, go STORE_WAIT.
//   CTRL & jump_en -> pc_redirect_en_out=1, pc_redirect_a_out=jump_a, flush_out=1, go FLUSH
//    (JAL/JALR still write rd in same cycle; flush never suppresses that write).
//   CTRL & !jump_en -> retire normally, stay RUN.
//  Pulses (pop, rf_wr_en, store_commit, redirect) last exactly one cycle; at most one retire per cycle.
//  Throughput: back-to-back retires every cycle in RUN (head sampled again in the pulse cycle).
//   ROB must present the new head the cycle after pop.
//  STORE_WAIT: no retire; on lsb_store_done_in (rdy_in high) return to RUN, retiring possible next cycle.
//   done arriving in same cycle as the commit pulse is accepted.
//  FLUSH: flush_out held high FLUSH_CYCLES cycles total (counted from first assert), no retire,
//   head inputs ignored; then RUN with flush_out=0.
//  lsb_store_done_in outside STORE_WAIT: ignored.
//  rdy_in low: state, counters and data outputs hold; all pulse outputs 0; flush_out holds value,
//   flush count paused.
//  rst_in mid-STORE_WAIT or mid-FLUSH: immediate return to RUN, all outputs 0, pending store discarded.
// TESTING
//  1 ADDI rd=5 val=0x1234 ready at head -> next cycle pop=1, rf_wr_en=1, rd=5, value=0x1234, cnt=1.
//  2 Three ready ALU ops back-to-back -> pop high 3 consecutive cycles, cnt=3; rd=0 op -> pop, no rf write.
//  3 SW ready then ADD ready -> store_commit pulse, ADD held until done pulsed 4 cycles later, then ADD retires.
//  4 JAL rd=1 val=0x104 jump_en, a=0x200 -> redirect=1 a=0x200, rf write x1=0x104, flush high 2 cycles, no pop meanwhile.
//  5 BEQ not taken -> pop only, no redirect/flush; rdy_in low 3 cycles with ready head -> no pop, state frozen.
//  6 rst_in asserted during STORE_WAIT / FLUSH (async, mid-cycle) -> outputs 0 at once, cnt=0, state RUN.

Source files
------------

// File: rtl/commit_ctrl.sv
// Commit controller at the ROB head: retires one entry per cycle, drives regfile writeback,
// store release to the LSB and PC redirect/flush for taken control flow.
module commit_ctrl #(
  parameter int TAG_W        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int INSTR_ID_W   = 6,
  parameter int ADDR_W       = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  head_valid_in,
  input  logic                  head_ready_in,
  input  logic [TAG_W-1:0]      head_tag_in,
  input  logic [INSTR_ID_W-1:0] head_instr_id_in,
  input  logic [4:0]            head_rd_in,
  input  logic [31:0]           head_value_in,
  input  logic                  head_jump_en_in,
  input  logic [ADDR_W-1:0]     head_jump_a_in,
  input  logic                  lsb_store_done_in,
  output logic                  rob_pop_out,
  output logic                  rf_wr_en_out,
  output logic [4:0]            rf_rd_out,
  output logic [31:0]           rf_value_out,
  output logic [TAG_W-1:0]      rf_tag_out,
  output logic                  lsb_store_commit_out,
  output logic                  pc_redirect_en_out,
  output logic [ADDR_W-1:0]     pc_redirect_a_out,
  output logic                  flush_out,
  output logic [31:0]           commit_cnt_out
);

  // Instruction ids mirror the shared config encoding: loads, stores, LUI/AUIPC, JAL/JALR, branches, ALU ops.
  localparam logic [INSTR_ID_W-1:0] ID_LHU  = INSTR_ID_W'(4);
  localparam logic [INSTR_ID_W-1:0] ID_SB   = INSTR_ID_W'(5);
  localparam logic [INSTR_ID_W-1:0] ID_SW   = INSTR_ID_W'(7);
  localparam logic [INSTR_ID_W-1:0] ID_LUI  = INSTR_ID_W'(8);
  localparam logic [INSTR_ID_W-1:0] ID_JAL  = INSTR_ID_W'(10);
  localparam logic [INSTR_ID_W-1:0] ID_JALR = INSTR_ID_W'(11);
  localparam logic [INSTR_ID_W-1:0] ID_BGEU = INSTR_ID_W'(17);
  localparam logic [INSTR_ID_W-1:0] ID_ADDI = INSTR_ID_W'(18);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {RUN, STORE_WAIT, FLUSH} state_t;

  state_t                  state, state_d;
  logic [FC_W-1:0]         flush_cnt, flush_cnt_d;
  logic                    pop_d, wr_d, store_d, redir_d, flush_d;
  logic [4:0]              rf_rd_d;
  logic [31:0]             rf_value_d, cnt_d;
  logic [TAG_W-1:0]        rf_tag_d;
  logic [ADDR_W-1:0]       pc_a_d;
  logic                    writes_rd, is_ctrl, is_store;

  assign writes_rd = (head_instr_id_in <= ID_LHU) ||
                     ((head_instr_id_in >= ID_LUI) && (head_instr_id_in <= ID_JALR)) ||
                     (head_instr_id_in >= ID_ADDI);
  assign is_ctrl   = (head_instr_id_in >= ID_JAL) && (head_instr_id_in <= ID_BGEU);
  assign is_store  = (head_instr_id_in >= ID_SB) && (head_instr_id_in <= ID_SW);

  always_comb begin
    state_d     = state;
    flush_cnt_d = flush_cnt;
    cnt_d       = commit_cnt_out;
    flush_d     = flush_out;
    rf_rd_d     = rf_rd_out;
    rf_value_d  = rf_value_out;
    rf_tag_d    = rf_tag_out;
    pc_a_d      = pc_redirect_a_out;
    pop_d       = 1'b0;
    wr_d        = 1'b0;
    store_d     = 1'b0;
    redir_d     = 1'b0;
    if (rdy_in) begin
      case (state)
        RUN: begin
          if (head_valid_in && head_ready_in) begin
            pop_d = 1'b1;
            cnt_d = commit_cnt_out + 32'd1;
            // JAL/JALR write their link register even though they also redirect.
            if (writes_rd && (head_rd_in != 5'd0)) begin
              wr_d       = 1'b1;
              rf_rd_d    = head_rd_in;
              rf_value_d = head_value_in;
              rf_tag_d   = head_tag_in;
            end
            if (is_store) begin
              store_d = 1'b1;
              state_d = STORE_WAIT;
            end else if (is_ctrl && head_jump_en_in) begin
              redir_d     = 1'b1;
              pc_a_d      = head_jump_a_in;
              flush_d     = 1'b1;
              flush_cnt_d = FC_W'(FLUSH_CYCLES - 1);
              state_d     = FLUSH;
            end
          end
        end
        STORE_WAIT: begin
          if (lsb_store_done_in) state_d = RUN;
        end
        FLUSH: begin
          if (flush_cnt == '0) begin
            flush_d = 1'b0;
            state_d = RUN;
          end else begin
            flush_cnt_d = flush_cnt - FC_W'(1);
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state                <= RUN;
      flush_cnt            <= '0;
      rob_pop_out          <= 1'b0;
      rf_wr_en_out         <= 1'b0;
      rf_rd_out            <= '0;
      rf_value_out         <= '0;
      rf_tag_out           <= '0;
      lsb_store_commit_out <= 1'b0;
      pc_redirect_en_out   <= 1'b0;
      pc_redirect_a_out    <= '0;
      flush_out            <= 1'b0;
      commit_cnt_out       <= '0;
    end else begin
      state                <= state_d;
      flush_cnt            <= flush_cnt_d;
      rob_pop_out          <= pop_d;
      rf_wr_en_out         <= wr_d;
      rf_rd_out            <= rf_rd_d;
      rf_value_out         <= rf_value_d;
      rf_tag_out           <= rf_tag_d;
      lsb_store_commit_out <= store_d;
      pc_redirect_en_out   <= redir_d;
      pc_redirect_a_out    <= pc_a_d;
      flush_out            <= flush_d;
      commit_cnt_out       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_commit_ctrl.sv
// Testbench for commit_ctrl: directed retire scenarios followed by randomized traffic,
// all compared against a transaction-level model of the commit rules.
module tb_commit_ctrl;

  localparam int TAG_W        = 4;
  localparam int FLUSH_CYCLES = 2;
  localparam int INSTR_ID_W   = 6;
  localparam int ADDR_W       = 32;

  localparam int LB = 0, LH = 1, LW = 2, LBU = 3, LHU = 4, SB = 5, SH = 6, SW = 7;
  localparam int LUI = 8, AUIPC = 9, JAL = 10, JALR = 11;
  localparam int BEQ = 12, BNE = 13, BLT = 14, BGE = 15, BLTU = 16, BGEU = 17;
  localparam int ADDI = 18, ADD = 27, LAST_ID = 36;

  logic                  clk_in = 1'b0;
  logic                  rst_in;
  logic                  rdy_in;
  logic                  head_valid_in;
  logic                  head_ready_in;
  logic [TAG_W-1:0]      head_tag_in;
  logic [INSTR_ID_W-1:0] head_instr_id_in;
  logic [4:0]            head_rd_in;
  logic [31:0]           head_value_in;
  logic                  head_jump_en_in;
  logic [ADDR_W-1:0]     head_jump_a_in;
  logic                  lsb_store_done_in;
  logic                  rob_pop_out;
  logic                  rf_wr_en_out;
  logic [4:0]            rf_rd_out;
  logic [31:0]           rf_value_out;
  logic [TAG_W-1:0]      rf_tag_out;
  logic                  lsb_store_commit_out;
  logic                  pc_redirect_en_out;
  logic [ADDR_W-1:0]     pc_redirect_a_out;
  logic                  flush_out;
  logic [31:0]           commit_cnt_out;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: retired count, whether a released store is outstanding,
  // remaining flush cycles, and the last values written out.
  logic [31:0]       m_cnt;
  bit                m_store_pending;
  int                m_flush_left;
  logic [4:0]        m_rf_rd;
  logic [31:0]       m_rf_value;
  logic [TAG_W-1:0]  m_rf_tag;
  logic [ADDR_W-1:0] m_pc_a;
  bit                e_pop, e_wr, e_store, e_redir;

  commit_ctrl #(
    .TAG_W(TAG_W), .FLUSH_CYCLES(FLUSH_CYCLES), .INSTR_ID_W(INSTR_ID_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .head_valid_in(head_valid_in), .head_ready_in(head_ready_in), .head_tag_in(head_tag_in),
    .head_instr_id_in(head_instr_id_in), .head_rd_in(head_rd_in), .head_value_in(head_value_in),
    .head_jump_en_in(head_jump_en_in), .head_jump_a_in(head_jump_a_in),
    .lsb_store_done_in(lsb_store_done_in),
    .rob_pop_out(rob_pop_out), .rf_wr_en_out(rf_wr_en_out), .rf_rd_out(rf_rd_out),
    .rf_value_out(rf_value_out), .rf_tag_out(rf_tag_out),
    .lsb_store_commit_out(lsb_store_commit_out), .pc_redirect_en_out(pc_redirect_en_out),
    .pc_redirect_a_out(pc_redirect_a_out), .flush_out(flush_out), .commit_cnt_out(commit_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic bit isStore(int id);
    return id inside {SB, SH, SW};
  endfunction

  function automatic bit isCtrl(int id);
    return id inside {JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU};
  endfunction

  function automatic bit writesRd(int id);
    return !isStore(id) && !(id inside {BEQ, BNE, BLT, BGE, BLTU, BGEU});
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
  endtask

  task automatic resetModel();
    m_cnt = '0; m_store_pending = 0; m_flush_left = 0;
    m_rf_rd = '0; m_rf_value = '0; m_rf_tag = '0; m_pc_a = '0;
    e_pop = 0; e_wr = 0; e_store = 0; e_redir = 0;
  endtask

  task automatic checkAll();
    checkOutput("pop",          32'(rob_pop_out),          32'(e_pop));
    checkOutput("rf_wr_en",     32'(rf_wr_en_out),         32'(e_wr));
    checkOutput("store_commit", 32'(lsb_store_commit_out), 32'(e_store));
    checkOutput("redirect",     32'(pc_redirect_en_out),   32'(e_redir));
    checkOutput("flush",        32'(flush_out),            32'(m_flush_left > 0));
    checkOutput("commit_cnt",   commit_cnt_out,            m_cnt);
    checkOutput("rf_rd",        32'(rf_rd_out),            32'(m_rf_rd));
    checkOutput("rf_value",     rf_value_out,              m_rf_value);
    checkOutput("rf_tag",       32'(rf_tag_out),           32'(m_rf_tag));
    checkOutput("redirect_a",   pc_redirect_a_out,         m_pc_a);
  endtask

  task automatic applyStimulus(input bit rdy, input bit valid, input bit ready, input int id,
                               input int rd, input logic [31:0] value, input int tag,
                               input bit jump, input logic [31:0] addr, input bit done);
    rdy_in            = rdy;
    head_valid_in     = valid;
    head_ready_in     = ready;
    head_instr_id_in  = INSTR_ID_W'(id);
    head_rd_in        = 5'(rd);
    head_value_in     = value;
    head_tag_in       = TAG_W'(tag);
    head_jump_en_in   = jump;
    head_jump_a_in    = addr;
    lsb_store_done_in = done;
  endtask

  // Predict the effect of the coming edge from the applied inputs, clock it, then compare.
  task automatic runCycle();
    int id;
    id = int'(head_instr_id_in);
    e_pop = 0; e_wr = 0; e_store = 0; e_redir = 0;
    if (rdy_in) begin
      if (m_flush_left > 0) begin
        m_flush_left--;
      end else if (m_store_pending) begin
        if (lsb_store_done_in) m_store_pending = 0;
      end else if (head_valid_in && head_ready_in) begin
        e_pop = 1;
        m_cnt = m_cnt + 1;
        if (writesRd(id) && head_rd_in != 0) begin
          e_wr = 1; m_rf_rd = head_rd_in; m_rf_value = head_value_in; m_rf_tag = head_tag_in;
        end
        if (isStore(id)) begin
          e_store = 1; m_store_pending = 1;
        end
        if (isCtrl(id) && head_jump_en_in) begin
          e_redir = 1; m_pc_a = head_jump_a_in; m_flush_left = FLUSH_CYCLES;
        end
      end
    end
    @(posedge clk_in);
    #1;
    checkAll();
  endtask

  // Asynchronous reset pulse placed mid-cycle, well away from either clock edge.
  task automatic midReset();
    #2 rst_in = 1'b1;
    #1;
    resetModel();
    checkAll();
    #1 rst_in = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    resetModel();
    #2 checkAll();
    @(posedge clk_in);
    #1 rst_in = 1'b0;

    // Single ADDI retire with writeback.
    applyStimulus(1, 1, 1, ADDI, 5, 32'h1234, 3, 0, 0, 0);
    runCycle();
    applyStimulus(1, 0, 0, ADDI, 0, 0, 0, 0, 0, 0);
    runCycle();

    // Back-to-back ALU retires, the last one targets x0.
    applyStimulus(1, 1, 1, ADD, 7, 32'hAAAA0001, 4, 0, 0, 0);
    runCycle();
    applyStimulus(1, 1, 1, ADDI, 9, 32'hBBBB0002, 5, 0, 0, 0);
    runCycle();
    applyStimulus(1, 1, 1, ADD, 0, 32'hCCCC0003, 6, 0, 0, 0);
    runCycle();

    // Store followed by an ADD that must wait for the store acknowledge.
    applyStimulus(1, 1, 1, SW, 0, 32'h0, 7, 0, 0, 0);
    runCycle();
    applyStimulus(1, 1, 1, ADD, 12, 32'h5555, 8, 0, 0, 0);
    repeat (3) runCycle();
    applyStimulus(1, 1, 1, ADD, 12, 32'h5555, 8, 0, 0, 1);
    runCycle();
    applyStimulus(1, 1, 1, ADD, 12, 32'h5555, 8, 0, 0, 0);
    runCycle();

    // Taken JAL: link write, redirect, flush window blocks the following head.
    applyStimulus(1, 1, 1, JAL, 1, 32'h104, 9, 1, 32'h200, 0);
    runCycle();
    applyStimulus(1, 1, 1, ADD, 3, 32'h77, 10, 0, 0, 0);
    repeat (3) runCycle();

    // Not-taken branch, then a frozen pipeline with a ready head.
    applyStimulus(1, 1, 1, BEQ, 4, 32'h99, 11, 0, 32'h300, 0);
    runCycle();
    applyStimulus(0, 1, 1, ADDI, 6, 32'h66, 12, 0, 0, 0);
    repeat (3) runCycle();

    // Asynchronous reset while waiting for a store, then while flushing.
    applyStimulus(1, 1, 1, SH, 0, 0, 13, 0, 0, 0);
    runCycle();
    midReset();
    applyStimulus(1, 1, 1, ADDI, 8, 32'h88, 14, 0, 0, 0);
    runCycle();
    applyStimulus(1, 1, 1, JALR, 2, 32'h40, 15, 1, 32'h400, 0);
    runCycle();
    midReset();
    applyStimulus(1, 1, 1, ADDI, 8, 32'h89, 1, 0, 0, 0);
    runCycle();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom % 8) != 0, ($urandom % 4) != 0, ($urandom % 4) != 0,
                    $urandom_range(0, LAST_ID),
                    (($urandom % 5) == 0) ? 0 : $urandom_range(1, 31),
                    $urandom, $urandom_range(0, 15), $urandom_range(0, 1), $urandom,
                    ($urandom % 4) == 0);
      runCycle();
    end

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
